// File: rtl/quad_step_pkg.sv
// Shared types and helpers for the quadrature step transmitter.
package quad_step_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Gray-coded phase so only one of qa/qb toggles per step.
   function automatic logic [1:0] phaseEncode(input logic [1:0] idx);
      logic [1:0] enc;
      case (idx)
         2'd0:    enc = 2'b00;
         2'd1:    enc = 2'b01;
         2'd2:    enc = 2'b11;
         default: enc = 2'b10;
      endcase
      return enc;
   endfunction

endpackage

// File: rtl/quad_step_divider.sv
// Loadable down-counter that ticks at zero and then reloads, setting the step period.
module quad_step_divider #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] reload_val_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign tick_o = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = tick_o ? reload_val_i : (cnt_q - DIV_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/quad_step_tx.sv
// Step-command transmitter: paces step pulses, drives quadrature phases and
// mirrors the downstream saturating position counter.
module quad_step_tx
   import quad_step_pkg::*;
#(
   parameter int POS_W = 4,
   parameter int CNT_W = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0] div,
   input  logic             abort,
   output logic             qa,
   output logic             qb,
   output logic             step_pulse,
   output logic             step_up,
   output logic [POS_W-1:0] pos,
   output logic             sat,
   output logic             busy,
   output logic             done
);

   localparam logic [POS_W-1:0] PosMax = '1;

   state_t           state_q;
   logic             dir_q;
   logic [CNT_W-1:0] remaining_q;
   logic [DIV_W-1:0] div_q;
   logic [POS_W-1:0] pos_q;
   logic [1:0]       phase_q;

   logic accept;
   logic divTick;
   logic stepFire;
   logic atBound;

   assign accept   = (state_q == IDLE) && cmd_valid;
   assign stepFire = (state_q == RUN) && divTick && !abort;
   assign atBound  = dir_q ? (pos_q == PosMax) : (pos_q == '0);

   quad_step_divider #(
      .DIV_W(DIV_W)
   ) u_divider (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (accept),
      .load_val_i   (div),
      .en_i         (state_q == RUN),
      .reload_val_i (div_q),
      .tick_o       (divTick)
   );

   // Abort wins over a step landing in the same cycle; a step at the boundary
   // still consumes one of the remaining steps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dir_q       <= 1'b0;
         remaining_q <= '0;
         div_q       <= '0;
         pos_q       <= '0;
         phase_q     <= 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  dir_q       <= cmd_dir;
                  remaining_q <= cmd_steps;
                  div_q       <= div;
                  state_q     <= (cmd_steps == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (divTick) begin
                  remaining_q <= remaining_q - CNT_W'(1);
                  if (!atBound) begin
                     if (dir_q) begin
                        pos_q   <= pos_q + POS_W'(1);
                        phase_q <= phase_q + 2'd1;
                     end else begin
                        pos_q   <= pos_q - POS_W'(1);
                        phase_q <= phase_q - 2'd1;
                     end
                  end
                  if (remaining_q == CNT_W'(1)) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign step_pulse = stepFire;
   assign sat        = stepFire && atBound;
   assign step_up    = dir_q;
   assign pos        = pos_q;
   assign {qa, qb}   = phaseEncode(phase_q);

endmodule

// File: tb/tb_quad_step_tx.sv
// Self-checking bench for quad_step_tx against a cycle-schedule model of step timing and position.
module tb_quad_step_tx;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir;
   logic [7:0] cmd_steps;
   logic [7:0] div;
   logic       abort;
   logic       qa;
   logic       qb;
   logic       step_pulse;
   logic       step_up;
   logic [3:0] pos;
   logic       sat;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   int mPos   = 0;
   int mPhase = 0;
   logic [1:0] phaseLut [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   quad_step_tx #(
      .POS_W(4),
      .CNT_W(8),
      .DIV_W(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .div        (div),
      .abort      (abort),
      .qa         (qa),
      .qb         (qb),
      .step_pulse (step_pulse),
      .step_up    (step_up),
      .pos        (pos),
      .sat        (sat),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one command and checks every cycle until done (or abort).
   // Cycle c=0 starts at the acceptance edge; step k is visible in cycle
   // k*(div+1)-1 and done in cycle steps*(div+1).
   task automatic runCmd(input bit dir, input int steps, input int dv,
                         input int abortAt, input bit holdValid, input string tag);
      int  period;
      int  total;
      bit  expPulse;
      bit  expSat;
      bit  aborted;
      period  = dv + 1;
      total   = steps * period;
      aborted = 1'b0;
      @(negedge clk);
      abort     = 1'b0;
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_steps = 8'(steps);
      div       = 8'(dv);
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_ready: ready=%b busy=%b, required ready=1 busy=0", tag, cmd_ready, busy);
      end
      for (int c = 0; c <= total; c++) begin
         @(negedge clk);
         cmd_valid = holdValid;
         abort     = (c == abortAt);
         #1;
         expPulse = (steps != 0) && (c < total) && (((c + 1) % period) == 0) && !abort;
         expSat   = expPulse && (dir ? (mPos == 15) : (mPos == 0));
         checks++;
         if (step_pulse !== expPulse || sat !== expSat) begin
            errors++;
            $display("[TB] FAIL %s_pulse c=%0d: pulse=%b sat=%b, required pulse=%b sat=%b",
                     tag, c, step_pulse, sat, expPulse, expSat);
         end
         checks++;
         if (pos !== 4'(mPos) || {qa, qb} !== phaseLut[mPhase]) begin
            errors++;
            $display("[TB] FAIL %s_pos c=%0d: pos=%0d qaqb=%b, required pos=%0d qaqb=%b",
                     tag, c, pos, {qa, qb}, mPos, phaseLut[mPhase]);
         end
         checks++;
         if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== (c == total) || step_up !== dir) begin
            errors++;
            $display("[TB] FAIL %s_status c=%0d: busy=%b ready=%b done=%b up=%b, required 1 0 %b %b",
                     tag, c, busy, cmd_ready, done, step_up, (c == total), dir);
         end
         if (expPulse && !expSat) begin
            mPos   = dir ? mPos + 1 : mPos - 1;
            mPhase = dir ? (mPhase + 1) % 4 : (mPhase + 3) % 4;
         end
         if (abort && c < total) begin
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         @(negedge clk);
         abort = 1'b0;
         #1;
         checks++;
         if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || step_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_abort_idle: busy=%b ready=%b done=%b pulse=%b, required 0 1 0 0",
                     tag, busy, cmd_ready, done, step_pulse);
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b0;
      cmd_steps = '0;
      div       = '0;
      abort     = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (pos !== 4'd0 || {qa, qb} !== 2'b00 || busy !== 1'b0 || done !== 1'b0 ||
          sat !== 1'b0 || step_pulse !== 1'b0 || step_up !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: pos=%0d qaqb=%b busy=%b done=%b sat=%b pulse=%b up=%b, required all 0",
                  pos, {qa, qb}, busy, done, sat, step_pulse, step_up);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: ready=%b, required 1", cmd_ready);
      end
      mPos   = 0;
      mPhase = 0;
   endtask

   task automatic test_up_move();
      runCmd(1'b1, 3, 1, -1, 1'b0, "up3");
   endtask

   task automatic test_up_saturation();
      runCmd(1'b1, 11, 0, -1, 1'b0, "up_to14");
      runCmd(1'b1, 3, 0, -1, 1'b0, "up_sat");
   endtask

   task automatic test_down_saturation();
      runCmd(1'b0, 15, 0, -1, 1'b0, "down_to0");
      runCmd(1'b0, 2, 0, -1, 1'b0, "down_sat");
   endtask

   task automatic test_abort();
      runCmd(1'b1, 5, 3, 4, 1'b0, "abort");
      runCmd(1'b1, 1, 0, -1, 1'b0, "after_abort");
   endtask

   task automatic test_zero_and_backpressure();
      runCmd(1'b1, 0, 2, -1, 1'b0, "zero");
      runCmd(1'b1, 2, 1, -1, 1'b1, "bp_held");
      runCmd(1'b1, 2, 1, -1, 1'b0, "bp_second");
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_once: busy=%b ready=%b, required busy=0 ready=1", busy, cmd_ready);
      end
   endtask

   task automatic test_random();
      int steps;
      int dv;
      int abortAt;
      bit dir;
      for (int i = 0; i < 24; i++) begin
         dir     = 1'($urandom_range(0, 1));
         steps   = $urandom_range(0, 6);
         dv      = $urandom_range(0, 3);
         abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, steps * (dv + 1)) : -1;
         runCmd(dir, steps, dv, abortAt, 1'b0, "rand");
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b1;
      cmd_steps = 8'd6;
      div       = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (pos !== 4'd0 || {qa, qb} !== 2'b00 || busy !== 1'b0 || done !== 1'b0 ||
          step_pulse !== 1'b0 || step_up !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset: pos=%0d qaqb=%b busy=%b done=%b pulse=%b up=%b, required all 0",
                  pos, {qa, qb}, busy, done, step_pulse, step_up);
      end
      rst_n  = 1'b1;
      mPos   = 0;
      mPhase = 0;
      runCmd(1'b1, 2, 0, -1, 1'b0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_up_move();
      test_up_saturation();
      test_down_saturation();
      test_abort();
      test_zero_and_backpressure();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
